gray_rd_arbiter: RTL and testbench
==================================

# gray_rd_arbiter

Round-robin arbiter sharing the single gray-image read port (14-bit pixel address, 8-bit data, 128×128 frame) between up to four pixel engines, e.g. the LBP engine and later filter engines. It sits between the engines' read requests and the gray memory, issues at most one read per cycle, and returns data to the winning requester after a fixed memory latency. Per-requester lock lets an engine keep the port for a multi-pixel window fetch.

## Interface
- N_REQ, 2: number of requesters, 1..4
- ADDR_W, 14: pixel address width ({row,col})
- DATA_W, 8: pixel width
- RD_LAT, 1: memory read latency in cycles, 1..3
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  N_REQ  per-requester read request, level; held until matching gnt
- lock  in  N_REQ  requester keeps ownership after its grant while lock=1
- addr  in  N_REQ*ADDR_W  per-requester address, slice i at [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant pulse; read for that requester issued this cycle
- rvalid  out  N_REQ  one-hot; rdata belongs to this requester
- rdata  out  DATA_W  read data, shared by all requesters
- mem_ready  in  1  level; image loaded and memory readable
- mem_req  out  1  read strobe to gray memory
- mem_addr  out  ADDR_W  read address to gray memory
- mem_data  in  DATA_W  memory data, valid RD_LAT cycles after mem_req

## Operation
- States: WAIT_RDY, ARB, LOCKED.
- WAIT_RDY: no grants; mem_req=0. Go to ARB on first mem_ready=1, never returns (mem_ready sampled once).
- ARB: if any req, grant the first requester at or after ptr (round-robin, wrapping N_REQ-1→0); gnt[w]=1, mem_req=1, mem_addr=addr[w] combinationally the same cycle. ptr←w+1 (mod N_REQ). If lock[w]=1 in the grant cycle → LOCKED with owner=w.
- LOCKED: only owner is eligible. If req[owner] then grant it each cycle. Exit to ARB the cycle lock[owner]=0 is sampled (grant in that cycle still allowed if req[owner]); other requesters starve meanwhile by design.
- No req in ARB: gnt=0, mem_req=0, mem_addr holds last value.
- Return path: RD_LAT-deep shift register of one-hot tags; rvalid = tag at depth RD_LAT, rdata = mem_data unregistered in that cycle. Back-to-back grants give back-to-back rvalid.
- Requesters change addr only after their gnt; arbiter does not buffer requests.

## Timing
- Reset values: gnt=0, rvalid=0, mem_req=0, mem_addr=0, rdata passes mem_data, ptr=0, state=WAIT_RDY, tag pipe cleared.
- Grant latency: 0 cycles from req (combinational decision on registered ptr/state).
- Read latency: rvalid exactly RD_LAT cycles after gnt.
- Throughput: one grant per cycle; with all requesters active, each served once per N_REQ cycles.
- Reset mid-transfer: in-flight tags discarded, no rvalid afterwards.
- lock asserted by a non-owner in LOCKED: ignored. req and lock both 0 for owner in LOCKED: back to ARB next cycle, no grant.
- N_REQ=1: ptr constant 0, arbiter degenerates to pass-through gated by mem_ready.

## Configuration
- GRAY_RD_ARB_STATS_EN defined: adds per-requester 16-bit saturating grant counters and output stat_cnt (N_REQ*16), cleared on reset, incremented on each gnt, stop at 16'hFFFF.
- Undefined: no counters, no stat_cnt port; functional behaviour identical.

## Structure
- Shared package: state enum (WAIT_RDY/ARB/LOCKED), frame constants (128, ADDR_W=14), MAX_REQ=4.
- Sub-module rr_pick: combinational round-robin selector (req vector, ptr → one-hot winner, valid); reused by later arbiters.

## Test plan
- mem_ready=0, req=2'b11 for 10 cycles → gnt=0, mem_req=0; mem_ready=1 → first gnt=2'b01 on next cycle.
- N_REQ=2, both req held, addrs 14'h0081/14'h0102 → gnt alternates 01,10,01…; rvalid follows 1 cycle later with mem_data matching each address.
- Requester 0 lock=1 for 8 grants with req1 pending → 8 consecutive gnt=01, then gnt=10 after lock drops.
- RD_LAT=3, 4 back-to-back grants → 4 back-to-back rvalid starting 3 cycles after first gnt, tags in order.
- reset pulsed with 2 reads in flight → no rvalid afterwards, state WAIT_RDY, all outputs 0.
- GRAY_RD_ARB_STATS_EN, 70000 grants to requester 1 → stat_cnt slice 1 = 16'hFFFF, slice 0 = 0.

Source files
------------

// File: rtl/gray_rd_arbiter_pkg.sv
// Shared types and constants for the gray-image read port arbiters.
package gray_rd_arbiter_pkg;

    localparam int unsigned FRAME_W      = 128;
    localparam int unsigned FRAME_H      = 128;
    localparam int unsigned FRAME_ADDR_W = 14;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned MAX_REQ      = 4;
    localparam int unsigned PTR_W        = 2;
    localparam int unsigned STAT_W       = 16;

    typedef logic [PTR_W-1:0] req_idx_t;

    typedef enum logic [1:0] {
        StWaitRdy,
        StArb,
        StLocked
    } arb_state_e;

    // Successor of idx in a ring of n requesters.
    function automatic req_idx_t next_idx(req_idx_t idx, int unsigned n);
        return (int'(idx) >= int'(n) - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/gray_rd_arbiter_if.sv
// Requester-side read bus of the gray-image arbiter (engines are master, arbiter is slave).
interface gray_rd_arbiter_if
    import gray_rd_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = FRAME_ADDR_W,
    parameter int unsigned DATA_W = PIX_W
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;

    modport master (
        output req, lock, addr,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, addr,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/gray_rd_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr_i, wrapping.
module gray_rd_arbiter_rr_pick
    import gray_rd_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  req_idx_t         ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output req_idx_t         idx_o,
    output logic             valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            for (int j = 0; j < int'(N_REQ); j++) begin
                if (!valid_o && req_i[j] && (j == (int'(ptr_i) + k) % int'(N_REQ))) begin
                    valid_o  = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = req_idx_t'(j);
                end
            end
        end
    end

endmodule

// File: rtl/gray_rd_arbiter.sv
// Round-robin arbiter for the shared gray-image read port with per-requester lock.
// Optional GRAY_RD_ARB_STATS_EN adds saturating per-requester grant counters on stat_cnt_o.
module gray_rd_arbiter
    import gray_rd_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = FRAME_ADDR_W,
    parameter int unsigned DATA_W = PIX_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    gray_rd_arbiter_if.slave  rd_if,
    input  logic              mem_ready_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i
`ifdef GRAY_RD_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0] stat_cnt_o
`endif
);

    arb_state_e        state_q, state_d;
    req_idx_t          ptr_q, ptr_d;
    req_idx_t          owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q;
    logic [N_REQ-1:0]  tag_q [RD_LAT];

    logic [N_REQ-1:0]  owner_oh;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  pick_gnt;
    req_idx_t          pick_ptr;
    req_idx_t          pick_idx;
    logic              pick_valid;

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_idx_t'(i) == owner_q) owner_oh[i] = 1'b1;
        end
    end

    // While locked the owner is the only candidate, so the picker starts from it.
    always_comb begin
        elig     = '0;
        pick_ptr = ptr_q;
        unique case (state_q)
            StArb: elig = rd_if.req;
            StLocked: begin
                elig     = rd_if.req & owner_oh;
                pick_ptr = owner_q;
            end
            default: elig = '0;
        endcase
    end

    gray_rd_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_i   (elig),
        .ptr_i   (pick_ptr),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign rd_if.gnt = pick_gnt;
    assign mem_req_o = pick_valid;

    always_comb begin
        mem_addr_o = addr_q;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_gnt[i]) mem_addr_o = rd_if.addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        unique case (state_q)
            StWaitRdy: begin
                if (mem_ready_i) state_d = StArb;
            end
            StArb: begin
                if (pick_valid) begin
                    ptr_d = next_idx(pick_idx, N_REQ);
                    if (|(pick_gnt & rd_if.lock)) begin
                        state_d = StLocked;
                        owner_d = pick_idx;
                    end
                end
            end
            StLocked: begin
                if (!(|(owner_oh & rd_if.lock))) state_d = StArb;
            end
            default: state_d = StWaitRdy;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWaitRdy;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= mem_addr_o;
        end
    end

    // One-hot tag rides alongside the memory latency to steer the returning pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(RD_LAT); i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= pick_gnt;
            for (int i = 1; i < int'(RD_LAT); i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign rd_if.rvalid = tag_q[RD_LAT-1];
    assign rd_if.rdata  = mem_data_i;

`ifdef GRAY_RD_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [N_REQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_REQ); i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (pick_gnt[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_stat
        assign stat_cnt_o[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT 1 and 3) driven by identical requesters.
module tb_gray_rd_arbiter;
    import gray_rd_arbiter_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 8;

    typedef struct {
        logic [NR-1:0] tag;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic mem_ready;
    logic [NR-1:0] req;
    logic [NR-1:0] lock;
    logic [NR*AW-1:0] addr_flat;
    int rem [NR];

    logic mem_req1, mem_req3;
    logic [AW-1:0] mem_addr1, mem_addr3;
    logic [DW-1:0] mem_data1, mem_data3;
    logic [AW-1:0] a1_q;
    logic [AW-1:0] a3_q [3];
`ifdef GRAY_RD_ARB_STATS_EN
    logic [NR*16-1:0] stat1, stat3;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Bench reference model state
    int m_st = 0;
    int m_ptr = 0;
    int m_owner = 0;
    logic [AW-1:0] m_last = '0;
    logic [NR-1:0] mgnt = '0;
    int m_cnt [NR];
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    always_comb begin
        req = '0;
        for (int i = 0; i < int'(NR); i++) req[i] = (rem[i] > 0);
    end

    gray_rd_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
    gray_rd_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    assign bus1.req  = req;
    assign bus1.lock = lock;
    assign bus1.addr = addr_flat;
    assign bus3.req  = req;
    assign bus3.lock = lock;
    assign bus3.addr = addr_flat;

    gray_rd_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .rd_if       (bus1),
        .mem_ready_i (mem_ready),
        .mem_req_o   (mem_req1),
        .mem_addr_o  (mem_addr1),
        .mem_data_i  (mem_data1)
`ifdef GRAY_RD_ARB_STATS_EN
        ,
        .stat_cnt_o  (stat1)
`endif
    );

    gray_rd_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .rd_if       (bus3),
        .mem_ready_i (mem_ready),
        .mem_req_o   (mem_req3),
        .mem_addr_o  (mem_addr3),
        .mem_data_i  (mem_data3)
`ifdef GRAY_RD_ARB_STATS_EN
        ,
        .stat_cnt_o  (stat3)
`endif
    );

    function automatic logic [DW-1:0] pix(logic [AW-1:0] a);
        return a[7:0] ^ {a[13:8], 2'b01} ^ 8'h5A;
    endfunction

    // Gray memory models with 1- and 3-cycle read latency
    always @(posedge clk) begin
        a1_q    <= mem_addr1;
        a3_q[0] <= mem_addr3;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end
    assign mem_data1 = pix(a1_q);
    assign mem_data3 = pix(a3_q[2]);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : model
        logic [NR-1:0] eg;
        logic [NR-1:0] exp_g;
        logic [NR-1:0] exp_rv;
        logic [AW-1:0] exp_a;
        int p;
        int w;
        if (reset) begin
            m_st = 0; m_ptr = 0; m_owner = 0; m_last = '0; mgnt = '0;
            q1.delete();
            q3.delete();
            for (int i = 0; i < int'(NR); i++) m_cnt[i] = 0;
            check_val("rst_gnt1", 32'(bus1.gnt), 32'(0));
            check_val("rst_rvalid1", 32'(bus1.rvalid), 32'(0));
            check_val("rst_rvalid3", 32'(bus3.rvalid), 32'(0));
            check_val("rst_mreq3", 32'(mem_req3), 32'(0));
            check_val("rst_maddr1", 32'(mem_addr1), 32'(0));
        end else begin
            eg = '0;
            p  = m_ptr;
            if (m_st == 1) eg = req;
            else if (m_st == 2) begin
                eg = req & (NR'(1) << m_owner);
                p  = m_owner;
            end
            w = -1;
            for (int k = 0; k < int'(NR); k++) begin
                if (w < 0 && eg[(p + k) % int'(NR)]) w = (p + k) % int'(NR);
            end
            exp_g = (w >= 0) ? (NR'(1) << w) : '0;
            exp_a = (w >= 0) ? addr_flat[w*AW +: AW] : m_last;
            check_val("gnt1", 32'(bus1.gnt), 32'(exp_g));
            check_val("gnt3", 32'(bus3.gnt), 32'(exp_g));
            check_val("mreq1", 32'(mem_req1), 32'(w >= 0));
            check_val("mreq3", 32'(mem_req3), 32'(w >= 0));
            check_val("maddr1", 32'(mem_addr1), 32'(exp_a));
            check_val("maddr3", 32'(mem_addr3), 32'(exp_a));
            if (w >= 0) begin
                q1.push_back('{exp_g, pix(exp_a), cyc + 1});
                q3.push_back('{exp_g, pix(exp_a), cyc + 3});
                m_last = exp_a;
                if (m_cnt[w] < 65535) m_cnt[w]++;
            end
            case (m_st)
                0: if (mem_ready) m_st = 1;
                1: if (w >= 0) begin
                    m_ptr = (w + 1) % int'(NR);
                    if (lock[w]) begin
                        m_st    = 2;
                        m_owner = w;
                    end
                end
                default: if (!lock[m_owner]) m_st = 1;
            endcase
            mgnt = exp_g;

            exp_rv = (q1.size() > 0 && q1[0].due == cyc) ? q1[0].tag : '0;
            check_val("rvalid1", 32'(bus1.rvalid), 32'(exp_rv));
            if (exp_rv != '0) begin
                check_val("rdata1", 32'(bus1.rdata), 32'(q1[0].data));
                void'(q1.pop_front());
            end
            exp_rv = (q3.size() > 0 && q3[0].due == cyc) ? q3[0].tag : '0;
            check_val("rvalid3", 32'(bus3.rvalid), 32'(exp_rv));
            if (exp_rv != '0) begin
                check_val("rdata3", 32'(bus3.rdata), 32'(q3[0].data));
                void'(q3.pop_front());
            end
        end
    end

    // Advance one cycle; granted requesters consume a request and move to a new address.
    task automatic step(input bit rand_addr);
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NR); i++) begin
            if (mgnt[i]) begin
                if (rem[i] > 0) rem[i] = rem[i] - 1;
                addr_flat[i*AW +: AW] = rand_addr ? AW'($urandom) : addr_flat[i*AW +: AW] + 1'b1;
            end
        end
    endtask

    initial begin
        int g0;
        reset = 1'b1;
        mem_ready = 1'b0;
        lock = '0;
        rem[0] = 0;
        rem[1] = 0;
        addr_flat = {14'h0102, 14'h0081};
        step(0);
        step(0);
        reset = 1'b0;

        // Memory not ready: requests must be held off
        rem[0] = 12;
        rem[1] = 12;
        repeat (10) step(0);
        mem_ready = 1'b1;
        for (int n = 0; n < 60 && (rem[0] > 0 || rem[1] > 0); n++) step(0);
        repeat (4) step(0);

        // Lock: requester 0 keeps the port for 8 grants while 1 waits
        rem[0] = 8;
        lock = 2'b11;
        g0 = 0;
        step(0);
        rem[1] = 3;
        for (int n = 0; n < 40 && (rem[0] > 0 || rem[1] > 0); n++) begin
            if (mgnt[0]) g0++;
            step(0);
            lock = (g0 < 7) ? 2'b11 : 2'b00;
        end
        lock = '0;
        repeat (4) step(0);

        // Random traffic with random locks
        for (int n = 0; n < 400; n++) begin
            step(1);
            for (int i = 0; i < int'(NR); i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 6));
            end
            lock = NR'($urandom);
        end
        lock = '0;

        // Reset with reads in flight
        rem[0] = 5;
        rem[1] = 5;
        step(0);
        step(0);
        reset = 1'b1;
        step(0);
        step(0);
        reset = 1'b0;
        for (int n = 0; n < 40 && (rem[0] > 0 || rem[1] > 0); n++) step(0);
        repeat (6) step(0);
        check_val("q1_drained", 32'(q1.size()), 32'(0));
        check_val("q3_drained", 32'(q3.size()), 32'(0));

`ifdef GRAY_RD_ARB_STATS_EN
        reset = 1'b1;
        step(0);
        reset = 1'b0;
        rem[1] = 70000;
        for (int n = 0; n < 70020 && rem[1] > 0; n++) step(0);
        repeat (4) step(0);
        check_val("stat1_r0", 32'(stat1[15:0]), 32'(m_cnt[0]));
        check_val("stat1_r1", 32'(stat1[31:16]), 32'(m_cnt[1]));
        check_val("stat3_r1", 32'(stat3[31:16]), 32'(16'hFFFF));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
